// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with live fill level, programmable almost-full/almost-empty thresholds
// and sticky overflow/underflow flags.
// Build option: define FIFO_FWFT_EN for first-word-fall-through reads (rdata shows the head
// word combinationally, rinc pops it); otherwise reads have one cycle of latency.
module sync_fifo_prog #(
  parameter int unsigned DATA_LINES = 8,
  parameter int unsigned ADDR_LINES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [DATA_LINES-1:0] wdata,
  input  logic                  rinc,
  output logic [DATA_LINES-1:0] rdata,
  output logic                  rvalid,
  input  logic [ADDR_LINES:0]   af_thresh,
  input  logic [ADDR_LINES:0]   ae_thresh,
  input  logic                  clr_err,
  output logic [ADDR_LINES:0]   level,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  half_full,
  output logic                  half_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned Depth = 2 ** ADDR_LINES;
  // DEPTH/2 expressed at level width
  localparam logic [ADDR_LINES:0] HalfLevel = {2'b01, {(ADDR_LINES - 1){1'b0}}};

  logic [DATA_LINES-1:0] mem [Depth];

  logic [ADDR_LINES:0] wptr_q, wptr_d;
  logic [ADDR_LINES:0] rptr_q, rptr_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                wr_acc, rd_acc;

  // Status derived from registered pointers; MSB is the wrap bit
  always_comb begin
    level        = wptr_q - rptr_q;
    rempty       = (wptr_q == rptr_q);
    wfull        = (wptr_q[ADDR_LINES] != rptr_q[ADDR_LINES]) &&
                   (wptr_q[ADDR_LINES-1:0] == rptr_q[ADDR_LINES-1:0]);
    half_full    = (level >= HalfLevel);
    half_empty   = (level <= HalfLevel);
    almost_full  = (af_thresh != '0) && (level >= af_thresh);
    almost_empty = (level <= ae_thresh);
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

  // Accept decisions, pointer advance and sticky error next-state
  always_comb begin
    wr_acc      = winc && !wfull;
    rd_acc      = rinc && !rempty;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) rptr_d = rptr_q + 1'b1;
    // A fresh error on the clearing edge keeps the flag set
    overflow_d  = (winc && wfull) || (overflow_q && !clr_err);
    underflow_d = (rinc && rempty) || (underflow_q && !clr_err);
  end

  // Pointer and error flag state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr_q[ADDR_LINES-1:0]] <= wdata;
  end

`ifdef FIFO_FWFT_EN
  // Head word is always presented; rinc consumes it
  always_comb begin
    rdata  = mem[rptr_q[ADDR_LINES-1:0]];
    rvalid = !rempty;
  end
`else
  logic [DATA_LINES-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;

  // Registered read port: capture head on accepted read, otherwise hold data
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = rd_acc;
    if (rd_acc) rdata_d = mem[rptr_q[ADDR_LINES-1:0]];
  end

  // Read data register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Drive read outputs from the registers
  always_comb begin
    rdata  = rdata_q;
    rvalid = rvalid_q;
  end
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed, table-driven bench for sync_fifo_prog (DATA_LINES=8, ADDR_LINES=4, DEPTH=16).
// Works in both the standard and the FIFO_FWFT_EN build.
module tb_sync_fifo_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       winc, rinc, clr_err;
  logic [7:0] wdata, rdata;
  logic       rvalid;
  logic [4:0] af_thresh, ae_thresh, level;
  logic       wfull, rempty, half_full, half_empty, almost_full, almost_empty;
  logic       overflow, underflow;
  logic [7:0] flags;

  int n_checks = 0;
  int n_errors = 0;

  sync_fifo_prog #(.DATA_LINES(8), .ADDR_LINES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .winc        (winc),
    .wdata       (wdata),
    .rinc        (rinc),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .af_thresh   (af_thresh),
    .ae_thresh   (ae_thresh),
    .clr_err     (clr_err),
    .level       (level),
    .wfull       (wfull),
    .rempty      (rempty),
    .half_full   (half_full),
    .half_empty  (half_empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  // {wfull, rempty, half_full, half_empty, almost_full, almost_empty, overflow, underflow}
  assign flags = {wfull, rempty, half_full, half_empty, almost_full, almost_empty,
                  overflow, underflow};

  typedef struct {
    logic       winc;
    logic [7:0] wdata;
    logic       rinc;
    logic       clr;
    logic       pop;    // a word is consumed on this row
    logic [7:0] pword;  // the word consumed
    logic [4:0] lvl;
    logic [7:0] flags;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    winc  = 1'b1;
    wdata = d;
    tick();
    winc  = 1'b0;
`ifdef FIFO_FWFT_EN
    chk("push_rvalid", rvalid, 1);
`else
    chk("push_rvalid", rvalid, 0);
`endif
  endtask

  task automatic pop(input logic [7:0] exp);
`ifdef FIFO_FWFT_EN
    chk("pop_rvalid", rvalid, 1);
    chk("pop_rdata", rdata, exp);
`endif
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
`ifndef FIFO_FWFT_EN
    chk("pop_rvalid", rvalid, 1);
    chk("pop_rdata", rdata, exp);
`endif
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] d;
    int         lv;

    tv[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 8'b00010100};
    tv[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00, 5'd2, 8'b00010100};
    tv[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00, 5'd3, 8'b00010100};
    tv[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 5'd2, 8'b00010100};
    tv[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 5'd1, 8'b00010100};
    tv[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 5'd0, 8'b01010100};
    tv[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 8'b01010101};  // read on empty
    tv[7]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 8'h00, 5'd1, 8'b00010101};  // w+r on empty
    tv[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 8'b00010100};  // clear
    tv[9]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'h44, 5'd1, 8'b00010100};  // w+r, level held
    tv[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h55, 5'd0, 8'b01010100};
    tv[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 8'b01010101};  // new error wins
    tv[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 8'b01010100};

    rst = 1'b0; winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; wdata = '0;
    af_thresh = 5'd12; ae_thresh = 5'd3;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("reset_level", level, 0);
    chk("reset_flags", flags, 8'b01010100);
    chk("reset_rvalid", rvalid, 0);
`ifndef FIFO_FWFT_EN
    chk("reset_rdata", rdata, 0);
`endif

    // Basic order, empty-read errors, simultaneous ops, error clearing
    for (int i = 0; i < 13; i++) begin
`ifdef FIFO_FWFT_EN
      if (tv[i].pop) begin
        chk("vec_pre_rvalid", rvalid, 1);
        chk("vec_pre_rdata", rdata, tv[i].pword);
      end
`endif
      winc = tv[i].winc; wdata = tv[i].wdata; rinc = tv[i].rinc; clr_err = tv[i].clr;
      tick();
      winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
      chk("vec_level", level, tv[i].lvl);
      chk("vec_flags", flags, tv[i].flags);
`ifdef FIFO_FWFT_EN
      chk("vec_rvalid", rvalid, tv[i].lvl != 0);
`else
      chk("vec_rvalid", rvalid, tv[i].pop);
      if (tv[i].pop) chk("vec_rdata", rdata, tv[i].pword);
`endif
    end

    // Fill to full with half/almost-full thresholds
    for (int k = 0; k < 16; k++) begin
      push(8'h80 + 8'(k));
      lv = k + 1;
      chk("fill_level", level, lv);
      chk("fill_half_full", half_full, lv >= 8);
      chk("fill_almost_full", almost_full, lv >= 12);
      chk("fill_wfull", wfull, lv == 16);
    end
    winc = 1'b1; wdata = 8'hEE;
    tick();
    winc = 1'b0;
    chk("ovf_level", level, 16);
    chk("ovf_flag", overflow, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovf_clear", overflow, 0);

    // Simultaneous write+read on full: write dropped, read accepted
`ifdef FIFO_FWFT_EN
    chk("full_wr_pre_rdata", rdata, 8'h80);
`endif
    winc = 1'b1; wdata = 8'hEF; rinc = 1'b1;
    tick();
    winc = 1'b0; rinc = 1'b0;
    chk("full_wr_level", level, 15);
    chk("full_wr_ovf", overflow, 1);
`ifndef FIFO_FWFT_EN
    chk("full_wr_rdata", rdata, 8'h80);
`endif
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // Drain with almost-empty threshold
    for (int k = 1; k < 16; k++) begin
      pop(8'h80 + 8'(k));
      lv = 15 - k;
      chk("drain_level", level, lv);
      chk("drain_almost_empty", almost_empty, lv <= 3);
      chk("drain_half_empty", half_empty, lv <= 8);
    end
    chk("drain_flags", flags, 8'b01010100);
`ifndef FIFO_FWFT_EN
    tick();
    chk("idle_rvalid", rvalid, 0);
    chk("idle_rdata_hold", rdata, 8'h8F);
`endif

    // almost_full disabled by a zero threshold
    af_thresh = 5'd0;
    for (int k = 0; k < 16; k++) push(8'(k));
    chk("af0_wfull", wfull, 1);
    chk("af0_almost_full", almost_full, 0);
    af_thresh = 5'd12;

    // Reset mid-stream discards contents
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) push(8'h60 + 8'(k));
    chk("pre_rst_level", level, 5);
    #3 rst = 1'b0;
    #1;
    chk("rst_level", level, 0);
    chk("rst_rempty", rempty, 1);
    chk("rst_rvalid", rvalid, 0);
    tick();
    rst = 1'b1;
    tick();
    push(8'hA5);
    pop(8'hA5);
    chk("rst_after_level", level, 0);

    // Streaming across many pointer wraps
    for (int k = 0; k < 120; k++) begin
      d = 8'($urandom_range(0, 255));
      q.push_back(d);
      push(d);
      pop(q.pop_front());
    end
    chk("stream_level", level, 0);
    chk("stream_ovf", overflow, 0);
    chk("stream_udf", underflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
